// File: rtl/start_rdy_timer_if.sv
// ---------------------------------------------------------------------------
// start_rdy_timer_if
//
// Purpose: groups the START/RDY handshake and status signals between the
// control FSM (master) and the start_rdy_timer responder (slave).
//
// Parameters:
//   WIDTH     width of LOAD_VAL and COUNT
//
// Signals:
//   START     request from initiator
//   LOAD_VAL  requested tick count, 0 selects the responder's default
//   RDY       one-cycle completion pulse
//   BUSY      high while timing
//   COUNT     remaining ticks
//   ERR       sticky retrigger-error flag
//   ABORT     synchronous cancel (only with START_RDY_TIMER_ABORT_EN)
// ---------------------------------------------------------------------------
interface start_rdy_timer_if #(
    parameter int WIDTH = 16
) ();

    logic             START;
    logic [WIDTH-1:0] LOAD_VAL;
    logic             RDY;
    logic             BUSY;
    logic [WIDTH-1:0] COUNT;
    logic             ERR;
`ifdef START_RDY_TIMER_ABORT_EN
    logic             ABORT;

    modport master (
        output START, LOAD_VAL, ABORT,
        input  RDY, BUSY, COUNT, ERR
    );

    modport slave (
        input  START, LOAD_VAL, ABORT,
        output RDY, BUSY, COUNT, ERR
    );
`else
    modport master (
        output START, LOAD_VAL,
        input  RDY, BUSY, COUNT, ERR
    );

    modport slave (
        input  START, LOAD_VAL,
        output RDY, BUSY, COUNT, ERR
    );
`endif

endinterface

// File: rtl/start_rdy_timer.sv
// ---------------------------------------------------------------------------
// start_rdy_timer
//
// Purpose: responder end of the START/RDY handshake. A START accepted in
// IDLE (or DONE) loads a tick count, the timer counts that many prescaled
// ticks and then emits a single-cycle RDY pulse. BUSY, the remaining count
// and a sticky retrigger error are exported for debug and LEDs.
// Moore machine: every output comes from a register, so there is no
// combinational path from START to any output.
//
// Optional feature macro: START_RDY_TIMER_ABORT_EN adds a synchronous
// ABORT input that cancels a run without producing RDY.
//
// Parameters:
//   WIDTH          width of the tick counter, LOAD_VAL and COUNT
//   DEFAULT_TICKS  ticks used when LOAD_VAL is 0 (1 .. 2^WIDTH-1)
//   PRESCALE       clock cycles per tick (>= 1)
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    slave side of start_rdy_timer_if (START, LOAD_VAL, [ABORT] in;
//          RDY, BUSY, COUNT, ERR out)
// ---------------------------------------------------------------------------
module start_rdy_timer #(
    parameter int WIDTH         = 16,
    parameter int DEFAULT_TICKS = 1000,
    parameter int PRESCALE      = 1
) (
    input  logic                clk,
    input  logic                reset,
    start_rdy_timer_if.slave    bus
);

    // A single-cycle prescale still needs a 1-bit register to keep the
    // compare logic uniform.
    localparam int PS_WIDTH = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_WIDTH-1:0] PS_LAST     = PS_WIDTH'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]    DEFAULT_VAL = WIDTH'(DEFAULT_TICKS);

    // Reject illegal configurations at elaboration time.
    if (DEFAULT_TICKS < 1 || DEFAULT_TICKS > (2 ** WIDTH) - 1) begin : g_bad_default
        $error("start_rdy_timer: DEFAULT_TICKS out of range 1..2^WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("start_rdy_timer: PRESCALE must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    count;
    logic [PS_WIDTH-1:0] prescaler;
    logic                rdy;
    logic                busy;
    logic                err;
    logic [WIDTH-1:0]    load_n;

    // A zero request selects the default tick count.
    assign load_n = (bus.LOAD_VAL == '0) ? DEFAULT_VAL : bus.LOAD_VAL;

    // Main sequencer. Acceptance in IDLE and DONE is identical so that
    // back-to-back requests are honoured straight out of DONE. A START that
    // arrives during RUN never touches the count, it only raises ERR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy <= 1'b0;
                    if (bus.START) begin
                        state     <= RUN;
                        count     <= load_n;
                        prescaler <= '0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end
                end

                RUN: begin
                    if (bus.START) begin
                        err <= 1'b1;
                    end
`ifdef START_RDY_TIMER_ABORT_EN
                    // Cancel wins over a tick completing in the same cycle.
                    if (bus.ABORT) begin
                        state     <= IDLE;
                        count     <= '0;
                        prescaler <= '0;
                        busy      <= 1'b0;
                    end else begin
`else
                    begin
`endif
                        if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            // The last tick lands on 0 and leaves RUN, so
                            // the counter can never wrap.
                            if (count <= WIDTH'(1)) begin
                                count <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                                rdy   <= 1'b1;
                            end else begin
                                count <= count - 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end

                DONE: begin
                    rdy <= 1'b0;
                    if (bus.START) begin
                        state     <= RUN;
                        count     <= load_n;
                        prescaler <= '0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    prescaler <= '0;
                    rdy       <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RDY   = rdy;
    assign bus.BUSY  = busy;
    assign bus.COUNT = count;
    assign bus.ERR   = err;

endmodule

// File: tb/tb_start_rdy_timer.sv
// ---------------------------------------------------------------------------
// tb_start_rdy_timer
//
// Purpose: drives two start_rdy_timer instances with the same request
// stream and compares them every cycle against a timeline model.
//   dut_a: PRESCALE=1, DEFAULT_TICKS=6
//   dut_b: PRESCALE=4, DEFAULT_TICKS=3
// The model remembers only when a request was accepted and its tick count,
// and derives the expected outputs from elapsed cycles: the run lasts
// N*PRESCALE edges, COUNT = N - elapsed/PRESCALE, then one RDY cycle.
// With START_RDY_TIMER_ABORT_EN defined the ABORT directed steps are added.
// ---------------------------------------------------------------------------
module tb_start_rdy_timer;

    localparam int WIDTH = 16;
    localparam int P_A   = 1;
    localparam int D_A   = 6;
    localparam int P_B   = 4;
    localparam int D_B   = 3;

    logic clk;
    logic reset;

    int checks;
    int errors;

    start_rdy_timer_if #(.WIDTH(WIDTH)) bus_a ();
    start_rdy_timer_if #(.WIDTH(WIDTH)) bus_b ();

    start_rdy_timer #(
        .WIDTH        (WIDTH),
        .DEFAULT_TICKS(D_A),
        .PRESCALE     (P_A)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    start_rdy_timer #(
        .WIDTH        (WIDTH),
        .DEFAULT_TICKS(D_B),
        .PRESCALE     (P_B)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model state, one entry per instance.
    int mp     [2];
    int md     [2];
    bit active [2];
    int start_e[2];
    int mn     [2];
    bit merr   [2];
    int edge_no;

    function automatic int phaseOf(input int i, input int e);
        int k;
        k = e - start_e[i];
        if (!active[i]) return 0;
        if (k < mn[i] * mp[i]) return 1;
        return 2;
    endfunction

    task automatic modelAccept(input int i, input int load);
        active[i]  = 1'b1;
        start_e[i] = edge_no;
        mn[i]      = (load == 0) ? md[i] : load;
        merr[i]    = 1'b0;
    endtask

    task automatic modelEdge(input int i, input bit start, input int load, input bit abort);
        int ph;
        ph = phaseOf(i, edge_no - 1);
        case (ph)
            0: if (start) modelAccept(i, load);
            1: begin
                if (start) merr[i] = 1'b1;
                if (abort) active[i] = 1'b0;
            end
            default: begin
                if (start) modelAccept(i, load);
                else       active[i] = 1'b0;
            end
        endcase
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0;
            merr[i]   = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare both instances against the model for the current cycle.
    task automatic checkOutput(input string tag);
        bit          e_rdy, e_busy;
        int          e_count;
        logic        o_rdy, o_busy, o_err;
        logic [31:0] o_count;
        int          ph, k;
        for (int i = 0; i < 2; i++) begin
            ph      = phaseOf(i, edge_no);
            k       = edge_no - start_e[i];
            e_rdy   = (ph == 2);
            e_busy  = (ph == 1);
            e_count = (ph == 1) ? mn[i] - (k / mp[i]) : 0;
            if (i == 0) begin
                o_rdy = bus_a.RDY; o_busy = bus_a.BUSY;
                o_count = 32'(bus_a.COUNT); o_err = bus_a.ERR;
            end else begin
                o_rdy = bus_b.RDY; o_busy = bus_b.BUSY;
                o_count = 32'(bus_b.COUNT); o_err = bus_b.ERR;
            end
            check($sformatf("%s_%s_rdy", tag, (i == 0) ? "a" : "b"), 32'(o_rdy), 32'(e_rdy));
            check($sformatf("%s_%s_busy", tag, (i == 0) ? "a" : "b"), 32'(o_busy), 32'(e_busy));
            check($sformatf("%s_%s_count", tag, (i == 0) ? "a" : "b"), o_count, 32'(e_count));
            check($sformatf("%s_%s_err", tag, (i == 0) ? "a" : "b"), 32'(o_err), 32'(merr[i]));
        end
    endtask

    // One clock cycle: drive inputs, take the edge, update model, check.
    task automatic applyStimulus(input bit start, input int load, input bit abort, input string tag);
        bus_a.START    = start;
        bus_b.START    = start;
        bus_a.LOAD_VAL = WIDTH'(load);
        bus_b.LOAD_VAL = WIDTH'(load);
`ifdef START_RDY_TIMER_ABORT_EN
        bus_a.ABORT = abort;
        bus_b.ABORT = abort;
`endif
        @(posedge clk);
        if (reset) begin
            edge_no++;
            modelEdge(0, start, load, abort);
            modelEdge(1, start, load, abort);
        end
        #1;
        if (reset) checkOutput(tag);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 300 && (active[0] || active[1]); n++) begin
            applyStimulus(1'b0, 0, 1'b0, "drain");
        end
    endtask

    initial begin
        int c;
        int pulses;

        checks  = 0;
        errors  = 0;
        edge_no = 0;
        mp[0] = P_A; md[0] = D_A;
        mp[1] = P_B; md[1] = D_B;
        modelReset();
        start_e[0] = 0; start_e[1] = 0; mn[0] = 1; mn[1] = 1;

        bus_a.START = 1'b0; bus_b.START = 1'b0;
        bus_a.LOAD_VAL = '0; bus_b.LOAD_VAL = '0;
`ifdef START_RDY_TIMER_ABORT_EN
        bus_a.ABORT = 1'b0; bus_b.ABORT = 1'b0;
`endif

        // Reset held for 3 cycles, then idle with START low.
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        reset = 1'b1;
        for (int n = 0; n < 20; n++) applyStimulus(1'b0, 0, 1'b0, "idle");

        // Basic timing on dut_a: LOAD_VAL=5, RDY after edge E0+5.
        applyStimulus(1'b1, 5, 1'b0, "basic");
        c = 0;
        while (!bus_a.RDY && c < 50) begin
            applyStimulus(1'b0, 0, 1'b0, "basic");
            c++;
        end
        check("basic_latency", 32'(c), 32'd5);
        applyStimulus(1'b0, 0, 1'b0, "basic_after");
        check("basic_rdy_width", 32'(bus_a.RDY), 32'd0);
        waitIdle();

        // Default count with prescale on dut_b: 3 ticks * 4 cycles.
        applyStimulus(1'b1, 0, 1'b0, "dflt");
        c = 0;
        while (!bus_b.RDY && c < 100) begin
            applyStimulus(1'b0, 0, 1'b0, "dflt");
            c++;
        end
        check("dflt_latency", 32'(c), 32'd12);
        waitIdle();

        // Retrigger: second START 4 cycles in is ignored but flags ERR.
        applyStimulus(1'b1, 10, 1'b0, "retrig");
        c = 0;
        while (!bus_a.RDY && c < 100) begin
            applyStimulus((c == 3), 3, 1'b0, "retrig");
            c++;
            if (c == 4) check("retrig_err", 32'(bus_a.ERR), 32'd1);
        end
        check("retrig_latency", 32'(c), 32'd10);
        waitIdle();
        applyStimulus(1'b1, 1, 1'b0, "retrig_clear");
        check("retrig_err_clear", 32'(bus_a.ERR), 32'd0);
        waitIdle();

        // START held high, LOAD_VAL=2: dut_a pulses RDY every 3 cycles.
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b1, 2, 1'b0, "b2b");
            if (bus_a.RDY) pulses++;
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        waitIdle();

        // Reset in the middle of a run on dut_a at COUNT=7.
        applyStimulus(1'b1, 9, 1'b0, "rst_run");
        c = 0;
        while (bus_a.COUNT != WIDTH'(7) && c < 50) begin
            applyStimulus(1'b0, 0, 1'b0, "rst_run");
            c++;
        end
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0, 0, 1'b0, "rst_after");
            if (bus_a.RDY) pulses++;
        end
        check("rst_no_rdy", 32'(pulses), 32'd0);

`ifdef START_RDY_TIMER_ABORT_EN
        // ABORT at COUNT=3: back to IDLE, no RDY.
        applyStimulus(1'b1, 8, 1'b0, "abort");
        c = 0;
        while (bus_a.COUNT != WIDTH'(3) && c < 50) begin
            applyStimulus(1'b0, 0, 1'b0, "abort");
            c++;
        end
        applyStimulus(1'b0, 0, 1'b1, "abort_hit");
        check("abort_busy", 32'(bus_a.BUSY), 32'd0);
        check("abort_count", 32'(bus_a.COUNT), 32'd0);
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0, 0, 1'b0, "abort_after");
            if (bus_a.RDY) pulses++;
        end
        check("abort_no_rdy", 32'(pulses), 32'd0);
        waitIdle();

        // ABORT together with the final tick still suppresses RDY.
        applyStimulus(1'b1, 2, 1'b0, "abort_last");
        applyStimulus(1'b0, 0, 1'b0, "abort_last");
        check("abort_last_count", 32'(bus_a.COUNT), 32'd1);
        applyStimulus(1'b0, 0, 1'b1, "abort_last_hit");
        check("abort_last_rdy", 32'(bus_a.RDY), 32'd0);
        waitIdle();
`endif

        // Randomized request stream against the timeline model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)), 1'b0, "rand");
        end
        waitIdle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/start_rdy_timer.md
Name: start_rdy_timer

Overview:
- Responder end of the START/RDY handshake used by the Moore sequencer in the timers task.
- Accepts a START request, counts a programmable number of prescaled ticks, then returns a one-cycle RDY pulse.
- Provides BUSY, remaining count and a sticky retrigger-error flag for debug and LEDs.
- Sits between the control FSM and the board clock domain; single clock, no CDC.

Parameters:
- WIDTH, 16, width of the tick counter and of LOAD_VAL/COUNT.
- DEFAULT_TICKS, 1000, tick count used when LOAD_VAL is 0; legal range 1..2^WIDTH-1.
- PRESCALE, 1, clock cycles per tick; legal range >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- START  input  1  request from initiator, sampled on clk rising edge.
- LOAD_VAL  input  WIDTH  tick count for the request; 0 selects DEFAULT_TICKS. Sampled only on the accepting edge.
- RDY  output  1  completion pulse, exactly one cycle wide.
- BUSY  output  1  high while timing.
- COUNT  output  WIDTH  remaining ticks.
- ERR  output  1  sticky flag: START seen while BUSY.

Behaviour:
- Reset (reset==0, async): state IDLE; RDY=0, BUSY=0, COUNT=0, ERR=0, prescaler=0.
  - Reset mid-run aborts immediately. No RDY is issued.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only (Moore); no combinational path from START to any output.
- Load value: N = (LOAD_VAL==0) ? DEFAULT_TICKS : LOAD_VAL, captured on the accepting edge.
- IDLE:
  - START==1 at edge E0 → RUN, COUNT<=N, prescaler<=0, ERR<=0.
  - START==0 → stay in IDLE.
- RUN:
  - BUSY=1.
  - Every cycle the prescaler increments.
  - When prescaler==PRESCALE-1: prescaler<=0 and COUNT<=COUNT-1.
  - If COUNT==1 at that tick → DONE.
- Timing:
  - DONE is entered at edge E0 + N*PRESCALE.
  - RDY is high for exactly the cycle following that edge.
  - For PRESCALE=1, N=1: RDY is high in the second cycle after START is sampled.
- DONE:
  - RDY=1, BUSY=0, COUNT=0.
  - START==1 → RUN with a new load (back-to-back accepted, ERR cleared).
  - Otherwise → IDLE.
- START while RUN: ignored (no reload, no timing disturbance); ERR<=1. ERR stays set until the next accepted START or reset.
- START held high continuously:
  - accepted in IDLE;
  - flags ERR on the next RUN cycle;
  - re-accepted in DONE, giving periodic RDY every N*PRESCALE+1 cycles.
- Arithmetic:
  - COUNT decrements unsigned and never wraps; it is never decremented below 1 in RUN.
  - Prescaler width is clog2(PRESCALE), minimum 1 bit.
- Illegal DEFAULT_TICKS=0 or PRESCALE=0: elaboration-time assertion failure.

Optional Feature:
- Macro: START_RDY_TIMER_ABORT_EN.
- Defined:
  - Adds port ABORT (input, 1, synchronous cancel).
  - ABORT==1 in RUN → IDLE next edge, COUNT<=0, no RDY, ERR unchanged.
  - ABORT has priority over tick completion in the same cycle.
  - ABORT in IDLE/DONE is ignored, and START is still honoured in DONE.
- Undefined: port ABORT absent; behaviour as above.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, START=0 for 20 cycles → RDY=0, BUSY=0, COUNT=0, ERR=0 throughout.
- Basic timing (PRESCALE=1): LOAD_VAL=5, one-cycle START at edge E0 → BUSY high for cycles E0+1..E0+5; COUNT goes 5,4,3,2,1; RDY high for exactly one cycle after edge E0+5; then IDLE.
- Default and prescale (PRESCALE=4, DEFAULT_TICKS=3): LOAD_VAL=0, START pulse → RDY one cycle after edge E0+12; COUNT steps every 4 cycles (3,2,1).
- Retrigger error: LOAD_VAL=10, START, then a second START 4 cycles later → RDY still after exactly 10 ticks; ERR=1 from the cycle after the second START until the next accepted START clears it.
- Back-to-back and reset abort: START held high with LOAD_VAL=2 → RDY pulses every 3 cycles. Separately, assert reset mid-RUN with COUNT=7 → outputs immediately 0, no RDY afterwards.
- With START_RDY_TIMER_ABORT_EN: LOAD_VAL=8, START, ABORT at COUNT=3 → IDLE next edge, COUNT=0, no RDY within 20 cycles. ABORT coincident with the final tick → no RDY.
